// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus decoder valid/ready handshake.
// master = fetch stage, slave = memory/decoder side.
interface instr_fetch_if #(
    parameter int unsigned INS_ADDR_WIDTH = 10,
    parameter int unsigned INS_WIDTH      = 33
);
    logic                      imem_en;
    logic [INS_ADDR_WIDTH-1:0] imem_addr;
    logic [INS_WIDTH-1:0]      imem_rdata;
    logic [INS_WIDTH-1:0]      instruction;
    logic [INS_ADDR_WIDTH-1:0] pc;
    logic                      ins_valid;
    logic                      ins_ready;

    modport master (
        output imem_en,
        output imem_addr,
        input  imem_rdata,
        output instruction,
        output pc,
        output ins_valid,
        input  ins_ready
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_rdata,
        input  instruction,
        input  pc,
        input  ins_valid,
        output ins_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, credit-limited imem reads, prefetch FIFO, HALT detect and drain.
// `define INSTR_FETCH_PERF_EN adds saturating stall/fetch counters (o_stall_cycles, o_fetched_count).
module instr_fetch #(
    parameter int unsigned             INS_ADDR_WIDTH = 10,
    parameter int unsigned             ADDR_WIDTH     = 10,
    parameter int unsigned             OPCODE_WIDTH   = 3,
    parameter int unsigned             INS_WIDTH      = OPCODE_WIDTH + 3 * ADDR_WIDTH,
    parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE    = 3'b111,
    parameter int unsigned             FIFO_DEPTH     = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [INS_ADDR_WIDTH-1:0] i_start_pc,
    output logic                      o_busy,
    output logic                      o_halted,
`ifdef INSTR_FETCH_PERF_EN
    output logic [31:0]               o_stall_cycles,
    output logic [31:0]               o_fetched_count,
`endif
    instr_fetch_if.master             bus
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned OP_MSB = OPCODE_WIDTH + 3 * ADDR_WIDTH - 1;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StHalted
    } state_e;

    state_e r_state;
    state_e w_state_next;

    logic [INS_ADDR_WIDTH-1:0] r_pc;
    logic [INS_ADDR_WIDTH-1:0] r_last_addr;
    logic                      r_inflight;

    logic [INS_WIDTH-1:0]      r_fifo_ins [FIFO_DEPTH];
    logic [INS_ADDR_WIDTH-1:0] r_fifo_pc  [FIFO_DEPTH];
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [CNT_W-1:0]          r_occ;

    logic                      w_start_acc;
    logic                      w_fetching;
    logic                      w_ret_halt;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_valid;
    logic                      w_issue;
    logic [CNT_W-1:0]          w_credit;
    logic [OPCODE_WIDTH-1:0]   w_opcode;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (i_start) w_state_next = StFetch;
            StFetch:  if (w_ret_halt) w_state_next = StDrain;
            StDrain:  if (r_occ == '0 && !r_inflight) w_state_next = StHalted;
            StHalted: if (i_start) w_state_next = StFetch;
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_busy      = 1'b0;
        o_halted    = 1'b0;
        w_start_acc = 1'b0;
        w_fetching  = 1'b0;
        unique case (r_state)
            StIdle:   w_start_acc = i_start;
            StFetch: begin
                o_busy     = 1'b1;
                w_fetching = 1'b1;
            end
            StDrain:  o_busy = 1'b1;
            StHalted: begin
                o_halted    = 1'b1;
                w_start_acc = i_start;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------- issue / return
    assign w_valid  = (r_occ != '0);
    assign w_pop    = w_valid & bus.ins_ready;
    assign w_credit = r_occ + CNT_W'(r_inflight) - CNT_W'(w_pop);
    assign w_issue  = w_fetching && (w_credit < CNT_W'(FIFO_DEPTH));

    assign w_opcode   = bus.imem_rdata[OP_MSB -: OPCODE_WIDTH];
    assign w_ret_halt = r_inflight && (w_opcode == HALT_OPCODE);
    // Returns landing after HALT (DRAIN) are past the end of the program and are dropped.
    assign w_push     = w_fetching && r_inflight && (w_opcode != HALT_OPCODE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc        <= '0;
            r_last_addr <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_start_acc) begin
                r_pc <= i_start_pc;
            end else if (w_issue) begin
                r_pc <= r_pc + 1'b1;
            end
            if (w_issue) begin
                r_last_addr <= r_pc;
            end
        end
    end

    assign bus.imem_en   = w_issue;
    assign bus.imem_addr = w_issue ? r_pc : r_last_addr;

    // ----------------------------------------------------------- prefetch FIFO
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_ins[r_wr_ptr] <= bus.imem_rdata;
            r_fifo_pc[r_wr_ptr]  <= r_last_addr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + 1'b1;
            end else if (!w_push && w_pop) begin
                r_occ <= r_occ - 1'b1;
            end
        end
    end

    assign bus.ins_valid   = w_valid;
    assign bus.instruction = w_valid ? r_fifo_ins[r_rd_ptr] : '0;
    assign bus.pc          = w_valid ? r_fifo_pc[r_rd_ptr] : '0;

    // ---------------------------------------------------- performance counters
`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_fetched_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || w_start_acc) begin
            r_stall_cycles  <= '0;
            r_fetched_count <= '0;
        end else begin
            if (w_valid && !bus.ins_ready && r_stall_cycles != '1) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_push && r_fetched_count != '1) begin
                r_fetched_count <= r_fetched_count + 32'd1;
            end
        end
    end

    assign o_stall_cycles  = r_stall_cycles;
    assign o_fetched_count = r_fetched_count;
`endif

    // ------------------------------------------------------------- assertions
    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        (w_push && !w_pop) |-> (r_occ < CNT_W'(FIFO_DEPTH)));

    a_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
        w_pop |-> (r_occ != '0));

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a 1-cycle-latency instruction memory model.
module tb_instr_fetch;

    localparam logic [32:0] HALT_W = {3'b111, 10'd0, 10'd0, 10'd0};
    localparam logic [32:0] JUNK_W = {3'b110, 10'd1, 10'd2, 10'd3};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [9:0] start_pc = '0;
    logic       busy;
    logic       halted;
`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] fetched_count;
`endif

    logic [32:0] mem [1024];

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_if #(.INS_ADDR_WIDTH(10), .INS_WIDTH(33)) bus ();

    instr_fetch #(
        .INS_ADDR_WIDTH(10),
        .ADDR_WIDTH    (10),
        .OPCODE_WIDTH  (3),
        .INS_WIDTH     (33),
        .HALT_OPCODE   (3'b111),
        .FIFO_DEPTH    (2)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_start_pc     (start_pc),
        .o_busy         (busy),
        .o_halted       (halted),
`ifdef INSTR_FETCH_PERF_EN
        .o_stall_cycles (stall_cycles),
        .o_fetched_count(fetched_count),
`endif
        .bus            (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];
    end

    function automatic logic [32:0] mk(input logic [2:0] op, input logic [9:0] a,
                                       input logic [9:0] b, input logic [9:0] c);
        return {op, a, b, c};
    endfunction

    function automatic logic [32:0] stream_word(input int k);
        return (k < 4) ? mk(3'(k), 10'd5, 10'd10, 10'd15) : HALT_W;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_junk();
        for (int a = 0; a < 1024; a++) mem[a] = JUNK_W;
    endtask

    task automatic load_stream();
        fill_junk();
        for (int k = 0; k < 4; k++) mem[k] = stream_word(k);
        mem[4] = HALT_W;
    endtask

    // Leaves the bench 1 time unit after the edge that sampled start.
    task automatic do_start(input logic [9:0] spc);
        start    = 1'b1;
        start_pc = spc;
        tick();
        start    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ins_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if (bus.ins_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected 0", bus.ins_valid);
        end
        n_checks++;
        if (bus.imem_en !== 1'b0 || bus.imem_addr !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_imem: got en=%b addr=%0d expected en=0 addr=0",
                     bus.imem_en, bus.imem_addr);
        end
        n_checks++;
        if (busy !== 1'b0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: got busy=%b halted=%b expected 0 0", busy, halted);
        end
        n_checks++;
        if (bus.instruction !== 33'd0 || bus.pc !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_head: got ins=%h pc=%0d expected 0 0", bus.instruction, bus.pc);
        end
`ifdef INSTR_FETCH_PERF_EN
        n_checks++;
        if (stall_cycles !== 32'd0 || fetched_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_perf: got stall=%0d fetched=%0d expected 0 0",
                     stall_cycles, fetched_count);
        end
`endif
    endtask

    task automatic test_streaming();
        int n;
        int halt_at;
        int last_pop;
        load_stream();
        bus.ins_ready = 1'b1;
        do_start(10'd0);
        n_checks++;
        if (bus.imem_en !== 1'b1 || bus.imem_addr !== 10'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_first_issue: got en=%b addr=%0d busy=%b expected 1 0 1",
                     bus.imem_en, bus.imem_addr, busy);
        end
        n = 0;
        halt_at = -1;
        last_pop = -1;
        for (int i = 1; i <= 40 && halt_at < 0; i++) begin
            tick();
            if (bus.ins_valid) begin
                n_checks++;
                if (n >= 4 || bus.instruction !== stream_word(n) || bus.pc !== 10'(n)
                    || i != n + 2) begin
                    n_fail++;
                    $display("FAIL stream_word: idx=%0d cycle=%0d got ins=%h pc=%0d expected ins=%h pc=%0d cycle=%0d",
                             n, i, bus.instruction, bus.pc, stream_word(n), n, n + 2);
                end
                last_pop = i;
                n++;
            end
            if (halted) halt_at = i;
        end
        n_checks++;
        if (n != 4 || last_pop != 5) begin
            n_fail++;
            $display("FAIL stream_count: got words=%0d last_pop=%0d expected 4 5", n, last_pop);
        end
        // Final pop at edge 6, halted visible after edge 8.
        n_checks++;
        if (halt_at != 8 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_halted: got halt_cycle=%0d busy=%b expected 8 0", halt_at, busy);
        end
`ifdef INSTR_FETCH_PERF_EN
        n_checks++;
        if (stall_cycles !== 32'd0 || fetched_count !== 32'd4) begin
            n_fail++;
            $display("FAIL stream_perf: got stall=%0d fetched=%0d expected 0 4",
                     stall_cycles, fetched_count);
        end
`endif
    endtask

    task automatic test_restart();
        int n;
        int halt_at;
        mem[8]  = mk(3'b101, 10'd5, 10'd10, 10'd15);
        mem[9]  = HALT_W;
        mem[10] = JUNK_W;
        bus.ins_ready = 1'b1;
        do_start(10'd8);
        n_checks++;
        if (halted !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_leave_halt: got halted=%b busy=%b expected 0 1", halted, busy);
        end
        n = 0;
        halt_at = -1;
        for (int i = 1; i <= 40 && halt_at < 0; i++) begin
            tick();
            start = 1'b0;
            if (bus.ins_valid) begin
                n_checks++;
                if (n != 0 || bus.pc !== 10'd8 || bus.instruction !== mk(3'b101, 10'd5, 10'd10, 10'd15)) begin
                    n_fail++;
                    $display("FAIL restart_word: idx=%0d got ins=%h pc=%0d expected ins=%h pc=8",
                             n, bus.instruction, bus.pc, mk(3'b101, 10'd5, 10'd10, 10'd15));
                end
                n++;
            end
            if (halted) halt_at = i;
            // start during FETCH must be ignored
            if (i == 1) begin
                start    = 1'b1;
                start_pc = 10'd0;
            end
        end
        n_checks++;
        if (n != 1 || halt_at != 5) begin
            n_fail++;
            $display("FAIL restart_end: got words=%0d halt_cycle=%0d expected 1 5", n, halt_at);
        end
`ifdef INSTR_FETCH_PERF_EN
        n_checks++;
        if (fetched_count !== 32'd1) begin
            n_fail++;
            $display("FAIL restart_perf: got fetched=%0d expected 1", fetched_count);
        end
`endif
    endtask

    task automatic test_backpressure();
        int n;
        int halt_at;
        int en_cnt;
        load_stream();
        bus.ins_ready = 1'b0;
        do_start(10'd0);
        en_cnt = int'(bus.imem_en);
        n = 0;
        halt_at = -1;
        for (int i = 1; i <= 60 && halt_at < 0; i++) begin
            tick();
            bus.ins_ready = (i >= 7);
            if (i <= 6) en_cnt += int'(bus.imem_en);
            if (i >= 2 && i <= 6) begin
                n_checks++;
                if (bus.ins_valid !== 1'b1 || bus.instruction !== stream_word(0)
                    || bus.pc !== 10'd0 || bus.imem_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_hold: cycle=%0d got valid=%b ins=%h pc=%0d en=%b expected 1 %h 0 0",
                             i, bus.ins_valid, bus.instruction, bus.pc, bus.imem_en, stream_word(0));
                end
            end
            if (bus.ins_valid && bus.ins_ready) begin
                n_checks++;
                if (n >= 4 || bus.instruction !== stream_word(n) || bus.pc !== 10'(n)) begin
                    n_fail++;
                    $display("FAIL bp_word: idx=%0d got ins=%h pc=%0d expected ins=%h pc=%0d",
                             n, bus.instruction, bus.pc, stream_word(n), n);
                end
                n++;
            end
            if (halted) halt_at = i;
        end
        n_checks++;
        if (en_cnt != 2) begin
            n_fail++;
            $display("FAIL bp_issue_limit: got %0d reads issued while stalled expected 2", en_cnt);
        end
        n_checks++;
        if (n != 4 || halt_at < 0) begin
            n_fail++;
            $display("FAIL bp_end: got words=%0d halt_cycle=%0d expected 4 and halted", n, halt_at);
        end
`ifdef INSTR_FETCH_PERF_EN
        n_checks++;
        if (stall_cycles !== 32'd5 || fetched_count !== 32'd4) begin
            n_fail++;
            $display("FAIL bp_perf: got stall=%0d fetched=%0d expected 5 4",
                     stall_cycles, fetched_count);
        end
`endif
    endtask

    task automatic test_wrap();
        int n;
        int halt_at;
        logic [9:0]  exp_pc [3];
        logic [32:0] exp_w  [3];
        exp_pc[0] = 10'd1022;
        exp_pc[1] = 10'd1023;
        exp_pc[2] = 10'd0;
        exp_w[0]  = mk(3'b010, 10'd7, 10'd8, 10'd9);
        exp_w[1]  = mk(3'b011, 10'd7, 10'd8, 10'd9);
        exp_w[2]  = mk(3'b100, 10'd7, 10'd8, 10'd9);
        fill_junk();
        mem[1022] = exp_w[0];
        mem[1023] = exp_w[1];
        mem[0]    = exp_w[2];
        mem[1]    = HALT_W;
        bus.ins_ready = 1'b1;
        do_start(10'd1022);
        n_checks++;
        if (bus.imem_addr !== 10'd1022) begin
            n_fail++;
            $display("FAIL wrap_first_addr: got %0d expected 1022", bus.imem_addr);
        end
        n = 0;
        halt_at = -1;
        for (int i = 1; i <= 40 && halt_at < 0; i++) begin
            tick();
            if (bus.ins_valid) begin
                n_checks++;
                if (n >= 3 || bus.pc !== exp_pc[n] || bus.instruction !== exp_w[n]) begin
                    n_fail++;
                    $display("FAIL wrap_word: idx=%0d got ins=%h pc=%0d expected ins=%h pc=%0d",
                             n, bus.instruction, bus.pc, exp_w[n % 3], exp_pc[n % 3]);
                end
                n++;
            end
            if (halted) halt_at = i;
        end
        n_checks++;
        if (n != 3 || halt_at < 0) begin
            n_fail++;
            $display("FAIL wrap_end: got words=%0d halt_cycle=%0d expected 3 and halted", n, halt_at);
        end
    endtask

    task automatic test_reset_midstream();
        int stale;
        load_stream();
        bus.ins_ready = 1'b1;
        do_start(10'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (bus.ins_valid !== 1'b0 || bus.imem_en !== 1'b0 || halted !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_after_reset: got valid=%b en=%b halted=%b busy=%b expected 0 0 0 0",
                     bus.ins_valid, bus.imem_en, halted, busy);
        end
        stale = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.ins_valid || bus.imem_en || busy) stale++;
        end
        n_checks++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL rm_stale: got %0d active cycles in IDLE expected 0", stale);
        end
    endtask

    initial begin
        bus.ins_ready = 1'b0;
        test_reset();
        test_streaming();
        test_restart();
        test_backpressure();
        test_wrap();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
